nvlink_vc_tx_scheduler: RTL and testbench
=========================================

# nvlink_vc_tx_scheduler

Credit-based transmit scheduler that shares the single NVLink TX framing/PCS/PHY path between `NUM_REQ` virtual-channel requesters. It round-robin arbitrates among requesters holding credits, registers the winning flit with a 24-bit link sequence number, and holds it until the serializer accepts it. It is gated by LTSSM `link_up` and sits directly upstream of `nvlink_framing_encode`.

## Interface
- `NUM_REQ`, 4: number of virtual-channel requesters; must be 2..8.
- `CREDIT_W`, 4: credit counter width.
- `INIT_CREDITS`, 8: credits loaded per VC on link-up; must be ≤ 2^CREDIT_W−1.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous reset, active-high.
- `link_up` in 1: from LTSSM.
- `req_valid` in NUM_REQ: per-VC flit available.
- `req_payload` in NUM_REQ×96: packed. VC i occupies bits [96i+95:96i].
- `req_coh_bits` in NUM_REQ×8: packed the same way as `req_payload`.
- `req_ready` out NUM_REQ: one-hot grant. A transfer occurs when `req_valid[i] & req_ready[i]`.
- `credit_return` in NUM_REQ: a one-cycle pulse returns one credit to VC i.
- `tx_valid` out 1: output flit valid.
- `tx_ready` in 1: serializer accepts the flit.
- `tx_payload` out 96, `tx_coh_bits` out 8: output flit fields.
- `tx_seq` out 24: sequence number of the flit.
- `tx_vc` out $clog2(NUM_REQ): source VC of the flit.
- `state` out 2: 0 = LINK_DOWN, 1 = INIT, 2 = ACTIVE.
- `credit_err` out 1: sticky; set when a credit return arrives while that VC's counter is at `INIT_CREDITS`.

## Operation
- **FSM transitions**
  - LINK_DOWN → INIT when `link_up` = 1.
  - INIT → ACTIVE unconditionally after one cycle.
  - Any state → LINK_DOWN when `link_up` = 0. This takes priority over every other transition.
- **INIT actions**
  - Load every credit counter with `INIT_CREDITS`.
  - Clear the sequence counter to 0.
  - Clear the round-robin pointer to 0.
  - Clear the output stage.
- **Grant eligibility:** grants are issued only in ACTIVE, and only when `link_up` = 1. VC i is eligible when `req_valid[i]` = 1 and `credit[i]` > 0.
- **Output stage free:** the stage is free when `!tx_valid | tx_ready`.
- **Round-robin:** when the stage is free, grant the first eligible VC searching upward from the pointer, wrapping. `req_ready` is combinational and is asserted only for that VC. The pointer then moves to granted+1 modulo NUM_REQ. With no grant, the pointer holds.
- **Credit counters**
  - A grant decrements the counter.
  - A `credit_return` increments the counter.
  - Grant and return for the same VC in the same cycle leave the counter unchanged.
  - A return at `INIT_CREDITS` (with no simultaneous grant) is dropped and sets `credit_err`.
  - Returns in LINK_DOWN and INIT are ignored.
- **Sequence numbers:** each grant loads `tx_seq` with the sequence counter, which then increments by 1. It wraps 0xFFFFFF → 0x000000.
- **Output hold:** `tx_*` outputs stay stable while `tx_valid & !tx_ready`.
- **Link loss:** on `link_up` falling, the held flit is discarded and `tx_valid` goes low the next cycle. That flit's credit is not restored; INIT reloads all credits anyway.
- **Clearing `credit_err`:** only by `rst`.

## Timing
- Reset values: `state` = LINK_DOWN; `tx_valid` = 0; `tx_payload`, `tx_coh_bits`, `tx_seq` and `tx_vc` = 0; `credit_err` = 0; all credits = 0; pointer = 0.
- `req_ready` is 0 whenever `state` ≠ ACTIVE.
- **Link-up to first flit:** with `link_up` rising at cycle N, `state` is INIT at N+1 and ACTIVE at N+2. The earliest grant is at N+2 and the earliest `tx_valid` at N+3.
- **Grant latency:** a grant in cycle G produces `tx_valid` in G+1.
- **Throughput:** one flit per cycle when `tx_ready` is held high.
- **Returned credits:** a credit returned in cycle C is usable for a grant in cycle C+1.
- **Mid-operation reset:** `rst` overrides everything on the next edge, including a held flit.

## Structure
- Package `nvlink_sched_pkg`:
  - `sched_state_e` enum.
  - `NVL_PAYLOAD_W` = 96, `NVL_COH_W` = 8, `NVL_SEQ_W` = 24.
  - `nvl_flit_req_t` struct (payload, coh_bits).
- Sub-module `rr_arbiter #(N)`: combinational one-hot grant from `eligible` and `pointer`. The pointer register lives in the parent.

## Test plan
- **Link bring-up:** `rst` for 2 cycles, then `link_up` = 1 at cycle 5 → `state` = INIT at cycle 6 and ACTIVE at cycle 7; every credit counter reads 8.
- **Round-robin sharing:** all 4 VCs valid, `tx_ready` = 1 → grant order 0, 1, 2, 3, 0, …; `tx_seq` = 0, 1, 2, …; `tx_vc` matches the grant order.
- **Credit exhaustion:** only VC2 valid, no returns → exactly 8 flits, then `req_ready[2]` stays 0. One `credit_return[2]` pulse → exactly one more flit.
- **Backpressure:** `tx_ready` = 0 for 5 cycles with `tx_valid` = 1 → outputs stable and no grants. `tx_ready` high → the next grant happens in the same cycle as acceptance.
- **Sequence wrap:** preload the sequence counter to 0xFFFFFE via force → consecutive flits carry 0xFFFFFE, 0xFFFFFF, 0x000000.
- **Link drop and credit error:** `link_up` low while a flit is held → `tx_valid` = 0 and `state` = LINK_DOWN next cycle. After re-train, the first flit has `tx_seq` = 0. A `credit_return` at a full VC → `credit_err` = 1 and stays set.

Source files
------------

// File: rtl/nvlink_sched_pkg.sv
// Shared types and widths for the NVLink VC transmit scheduler.
package nvlink_sched_pkg;

  localparam int NVL_PAYLOAD_W = 96;
  localparam int NVL_COH_W     = 8;
  localparam int NVL_SEQ_W     = 24;

  typedef enum logic [1:0] {
    ST_LINK_DOWN = 2'd0,
    ST_INIT      = 2'd1,
    ST_ACTIVE    = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [NVL_PAYLOAD_W-1:0] payload;
    logic [NVL_COH_W-1:0]     coh_bits;
  } nvl_flit_req_t;

endpackage

// File: rtl/nvlink_vc_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first eligible
// requester at or above the pointer, wrapping. The pointer is owned by the parent.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  grant
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  // NOTE: every output of always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(pointer) + k) % N);
      if (!w_found && eligible[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nvlink_vc_tx_scheduler.sv
// Credit-based round-robin TX scheduler sharing one NVLink TX path among
// NUM_REQ virtual channels; registers the winning flit with a link sequence number.
module nvlink_vc_tx_scheduler
  import nvlink_sched_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int CREDIT_W     = 4,
  parameter  int INIT_CREDITS = 8,
  localparam int PTR_W        = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             link_up,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*NVL_PAYLOAD_W-1:0] req_payload,
  input  logic [NUM_REQ*NVL_COH_W-1:0]     req_coh_bits,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               credit_return,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic [NVL_PAYLOAD_W-1:0]         tx_payload,
  output logic [NVL_COH_W-1:0]             tx_coh_bits,
  output logic [NVL_SEQ_W-1:0]             tx_seq,
  output logic [PTR_W-1:0]                 tx_vc,
  output logic [1:0]                       state,
  output logic                             credit_err
);

  localparam logic [CREDIT_W-1:0] LP_INIT_CREDITS = CREDIT_W'(INIT_CREDITS);

  sched_state_e                      r_state, w_state_nxt;
  logic [NUM_REQ-1:0][CREDIT_W-1:0]  r_credit;
  logic [NVL_SEQ_W-1:0]              r_seq_cnt;
  logic [PTR_W-1:0]                  r_ptr;
  logic                              r_tx_valid;
  logic [NVL_PAYLOAD_W-1:0]          r_tx_payload;
  logic [NVL_COH_W-1:0]              r_tx_coh;
  logic [NVL_SEQ_W-1:0]              r_tx_seq;
  logic [PTR_W-1:0]                  r_tx_vc;
  logic                              r_credit_err;

  nvl_flit_req_t                     w_req [NUM_REQ];
  nvl_flit_req_t                     w_sel;
  logic [NUM_REQ-1:0]                w_has_credit;
  logic [NUM_REQ-1:0]                w_eligible;
  logic [NUM_REQ-1:0]                w_grant;
  logic                              w_grant_any;
  logic [PTR_W-1:0]                  w_grant_idx;
  logic [PTR_W-1:0]                  w_ptr_nxt;
  logic                              w_can_grant;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req[g] = {req_payload[g*NVL_PAYLOAD_W +: NVL_PAYLOAD_W],
                       req_coh_bits[g*NVL_COH_W +: NVL_COH_W]};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_LINK_DOWN;
    else     r_state <= w_state_nxt;
  end

  // Link loss overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (!link_up) begin
      w_state_nxt = ST_LINK_DOWN;
    end else begin
      case (r_state)
        ST_LINK_DOWN: w_state_nxt = ST_INIT;
        ST_INIT:      w_state_nxt = ST_ACTIVE;
        ST_ACTIVE:    w_state_nxt = ST_ACTIVE;
        default:      w_state_nxt = ST_LINK_DOWN;
      endcase
    end
  end

  always_comb begin
    w_has_credit = '0;
    for (int i = 0; i < NUM_REQ; i++) w_has_credit[i] = (r_credit[i] != '0);
  end

  assign w_can_grant = (r_state == ST_ACTIVE) && link_up && (!r_tx_valid || tx_ready);
  assign w_eligible  = w_can_grant ? (req_valid & w_has_credit) : '0;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .eligible (w_eligible),
    .pointer  (r_ptr),
    .grant    (w_grant)
  );

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_grant_idx = PTR_W'(i);
    end
  end

  assign w_grant_any = |w_grant;
  assign w_sel       = w_req[w_grant_idx];
  assign w_ptr_nxt   = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the credit array is a handful of flops that reset must
      // define; a true RAM would be left unreset and cleared by INIT.
      r_credit     <= '0;
      r_seq_cnt    <= '0;
      r_ptr        <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_payload <= '0;
      r_tx_coh     <= '0;
      r_tx_seq     <= '0;
      r_tx_vc      <= '0;
      r_credit_err <= 1'b0;
    end else if (!link_up) begin
      r_tx_valid <= 1'b0;
    end else if (r_state == ST_INIT) begin
      for (int i = 0; i < NUM_REQ; i++) r_credit[i] <= LP_INIT_CREDITS;
      r_seq_cnt    <= '0;
      r_ptr        <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_payload <= '0;
      r_tx_coh     <= '0;
      r_tx_seq     <= '0;
      r_tx_vc      <= '0;
    end else if (r_state == ST_ACTIVE) begin
      if (w_grant_any) begin
        r_tx_valid   <= 1'b1;
        r_tx_payload <= w_sel.payload;
        r_tx_coh     <= w_sel.coh_bits;
        r_tx_seq     <= r_seq_cnt;
        r_tx_vc      <= w_grant_idx;
        r_seq_cnt    <= r_seq_cnt + 1'b1;
        r_ptr        <= w_ptr_nxt;
      end else if (tx_ready) begin
        r_tx_valid <= 1'b0;
      end
      // Counters never exceed INIT_CREDITS; an extra return is flagged and dropped.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i] && !credit_return[i]) begin
          r_credit[i] <= r_credit[i] - 1'b1;
        end else if (credit_return[i] && !w_grant[i]) begin
          if (r_credit[i] == LP_INIT_CREDITS) r_credit_err <= 1'b1;
          else                                r_credit[i]  <= r_credit[i] + 1'b1;
        end
      end
    end
  end

  assign req_ready   = w_grant;
  assign tx_valid    = r_tx_valid;
  assign tx_payload  = r_tx_payload;
  assign tx_coh_bits = r_tx_coh;
  assign tx_seq      = r_tx_seq;
  assign tx_vc       = r_tx_vc;
  assign state       = r_state;
  assign credit_err  = r_credit_err;

endmodule

// File: tb/tb_nvlink_vc_tx_scheduler.sv
// Directed bench for nvlink_vc_tx_scheduler: bring-up, round-robin, credits,
// backpressure, sequence wrap, link loss, credit error and mid-run reset.
module tb_nvlink_vc_tx_scheduler;
  import nvlink_sched_pkg::*;

  localparam int N = 4;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       link_up = 1'b0;
  logic [N-1:0]               req_valid = '0;
  logic [N*NVL_PAYLOAD_W-1:0] req_payload;
  logic [N*NVL_COH_W-1:0]     req_coh_bits;
  logic [N-1:0]               req_ready;
  logic [N-1:0]               credit_return = '0;
  logic                       tx_valid;
  logic                       tx_ready = 1'b0;
  logic [NVL_PAYLOAD_W-1:0]   tx_payload;
  logic [NVL_COH_W-1:0]       tx_coh_bits;
  logic [NVL_SEQ_W-1:0]       tx_seq;
  logic [1:0]                 tx_vc;
  logic [1:0]                 state;
  logic                       credit_err;

  int                         n_checks = 0;
  int                         n_fail   = 0;
  logic [NVL_SEQ_W-1:0]       exp_seq;

  nvlink_vc_tx_scheduler #(.NUM_REQ(N), .CREDIT_W(4), .INIT_CREDITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .link_up       (link_up),
    .req_valid     (req_valid),
    .req_payload   (req_payload),
    .req_coh_bits  (req_coh_bits),
    .req_ready     (req_ready),
    .credit_return (credit_return),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_payload    (tx_payload),
    .tx_coh_bits   (tx_coh_bits),
    .tx_seq        (tx_seq),
    .tx_vc         (tx_vc),
    .state         (state),
    .credit_err    (credit_err)
  );

  always #5 clk = ~clk;

  function automatic logic [NVL_PAYLOAD_W-1:0] pl(input int i);
    return {32'hDEAD_0000 + 32'(i), 32'h1234_5678 ^ 32'(i), 32'h0F0F_0000 + 32'(i)};
  endfunction

  function automatic logic [NVL_COH_W-1:0] ch(input int i);
    return 8'h80 + 8'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; link_up = 1'b0; req_valid = '0; credit_return = '0; tx_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    n_checks++; if (tx_seq !== 24'd0 || tx_vc !== 2'd0) begin n_fail++; $display("FAIL reset_seq_vc got=%h/%0d exp=0/0", tx_seq, tx_vc); end
    n_checks++; if (tx_payload !== '0 || tx_coh_bits !== '0) begin n_fail++; $display("FAIL reset_flit got=%h/%h exp=0", tx_payload, tx_coh_bits); end
    n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_credit_err got=%b exp=0", credit_err); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (dut.r_credit[i] !== 4'd0) begin n_fail++; $display("FAIL reset_credit%0d got=%0d exp=0", i, dut.r_credit[i]); end
    end
    req_valid = 4'hF;
    step(); step();
    n_checks++; if (state !== 2'd0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_link_down got=%0d/%b exp=0/0000", state, req_ready); end
    req_valid = '0;
  endtask

  task automatic test_bring_up();
    link_up = 1'b1;
    step();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL bringup_init got=%0d exp=1", state); end
    req_valid = 4'hF; tx_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL init_no_grant got=%b exp=0000", req_ready); end
    req_valid = '0;
    step();
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL bringup_active got=%0d exp=2", state); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL bringup_tx_valid got=%b exp=0", tx_valid); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (dut.r_credit[i] !== 4'd8) begin n_fail++; $display("FAIL init_credit%0d got=%0d exp=8", i, dut.r_credit[i]); end
    end
  endtask

  task automatic test_round_robin();
    req_valid = 4'hF; tx_ready = 1'b1; exp_seq = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++; if (req_ready !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4))); end
      step();
      n_checks++;
      if (tx_valid !== 1'b1 || tx_vc !== 2'(k % 4) || tx_seq !== exp_seq ||
          tx_payload !== pl(k % 4) || tx_coh_bits !== ch(k % 4)) begin
        n_fail++;
        $display("FAIL rr_flit%0d got=v%b vc%0d seq%h pl%h coh%h exp=v1 vc%0d seq%h pl%h coh%h",
                 k, tx_valid, tx_vc, tx_seq, tx_payload, tx_coh_bits, k % 4, exp_seq, pl(k % 4), ch(k % 4));
      end
      exp_seq++;
    end
    req_valid = '0; credit_return = 4'hF;
    step();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got=%b exp=0", tx_valid); end
    step();
    credit_return = '0;
    for (int i = 0; i < N; i++) begin
      n_checks++; if (dut.r_credit[i] !== 4'd8) begin n_fail++; $display("FAIL returned_credit%0d got=%0d exp=8", i, dut.r_credit[i]); end
    end
  endtask

  task automatic test_credit_exhaustion();
    int   n_grants;
    logic got;
    n_grants = 0;
    req_valid = 4'b0100; tx_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      got = req_ready[2];
      n_checks++; if (req_ready !== ((k < 8) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL exhaust_grant%0d got=%b exp=%b", k, req_ready, (k < 8) ? 4'b0100 : 4'b0000); end
      if (got) n_grants++;
      step();
      if (got) begin
        n_checks++; if (tx_seq !== exp_seq || tx_vc !== 2'd2) begin n_fail++; $display("FAIL exhaust_seq%0d got=%h/%0d exp=%h/2", k, tx_seq, tx_vc, exp_seq); end
        exp_seq++;
      end
    end
    n_checks++; if (n_grants != 8) begin n_fail++; $display("FAIL exhaust_count got=%0d exp=8", n_grants); end
    credit_return = 4'b0100;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL return_same_cycle got=%b exp=0000", req_ready); end
    step();
    credit_return = '0;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL return_next_cycle got=%b exp=0100", req_ready); end
    step();
    n_checks++; if (tx_seq !== exp_seq || tx_valid !== 1'b1) begin n_fail++; $display("FAIL return_flit got=%h/%b exp=%h/1", tx_seq, tx_valid, exp_seq); end
    exp_seq++;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL return_single got=%b exp=0000", req_ready); end
    req_valid = '0;
    step(); step();
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0011; tx_ready = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_first_grant got=%b exp=0001", req_ready); end
    step();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_vc !== 2'd0 || tx_seq !== exp_seq || tx_payload !== pl(0) || tx_coh_bits !== ch(0)) begin
        n_fail++;
        $display("FAIL bp_hold%0d got=v%b vc%0d seq%h exp=v1 vc0 seq%h", k, tx_valid, tx_vc, tx_seq, exp_seq);
      end
      #1;
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_no_grant%0d got=%b exp=0000", k, req_ready); end
      step();
    end
    exp_seq++;
    tx_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_grant got=%b exp=0010", req_ready); end
    step();
    n_checks++; if (tx_vc !== 2'd1 || tx_seq !== exp_seq || tx_payload !== pl(1)) begin n_fail++; $display("FAIL bp_next_flit got=vc%0d seq%h exp=vc1 seq%h", tx_vc, tx_seq, exp_seq); end
    exp_seq++;
    req_valid = '0;
    step();
  endtask

  task automatic test_seq_wrap();
    logic [NVL_SEQ_W-1:0] wrap_seq [3];
    logic [1:0]           wrap_vc  [3];
    wrap_seq = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000};
    wrap_vc  = '{2'd3, 2'd0, 2'd1};
    force dut.r_seq_cnt = 24'hFFFFFE;
    step();
    release dut.r_seq_cnt;
    req_valid = 4'b1011; tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (tx_seq !== wrap_seq[k] || tx_vc !== wrap_vc[k]) begin n_fail++; $display("FAIL wrap%0d got=%h/vc%0d exp=%h/vc%0d", k, tx_seq, tx_vc, wrap_seq[k], wrap_vc[k]); end
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_link_drop();
    req_valid = 4'b0001; tx_ready = 1'b0;
    step();
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL drop_held got=%b exp=1", tx_valid); end
    req_valid = '0; link_up = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL drop_no_grant got=%b exp=0000", req_ready); end
    step();
    n_checks++; if (tx_valid !== 1'b0 || state !== 2'd0) begin n_fail++; $display("FAIL drop_discard got=v%b st%0d exp=v0 st0", tx_valid, state); end
    link_up = 1'b1;
    step();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL retrain_init got=%0d exp=1", state); end
    step();
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL retrain_active got=%0d exp=2", state); end
    req_valid = 4'b0001; tx_ready = 1'b1;
    step();
    n_checks++; if (tx_valid !== 1'b1 || tx_seq !== 24'd0 || tx_vc !== 2'd0) begin n_fail++; $display("FAIL retrain_first got=v%b seq%h vc%0d exp=v1 seq0 vc0", tx_valid, tx_seq, tx_vc); end
    req_valid = '0;
    step();
  endtask

  task automatic test_credit_err();
    n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL err_before got=%b exp=0", credit_err); end
    credit_return = 4'b0010;
    step();
    credit_return = '0;
    n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL err_set got=%b exp=1", credit_err); end
    n_checks++; if (dut.r_credit[1] !== 4'd8) begin n_fail++; $display("FAIL err_no_overflow got=%0d exp=8", dut.r_credit[1]); end
    step(); step(); step();
    n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", credit_err); end
  endtask

  task automatic test_mid_reset();
    req_valid = 4'b0100; tx_ready = 1'b0;
    step();
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL mrst_held got=%b exp=1", tx_valid); end
    rst = 1'b1;
    step();
    n_checks++; if (tx_valid !== 1'b0 || state !== 2'd0 || credit_err !== 1'b0 || tx_seq !== 24'd0) begin
      n_fail++; $display("FAIL mrst_clear got=v%b st%0d err%b seq%h exp=v0 st0 err0 seq0", tx_valid, state, credit_err, tx_seq);
    end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mrst_req_ready got=%b exp=0000", req_ready); end
    rst = 1'b0; req_valid = '0;
    step();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      req_payload[i*NVL_PAYLOAD_W +: NVL_PAYLOAD_W] = pl(i);
      req_coh_bits[i*NVL_COH_W +: NVL_COH_W]        = ch(i);
    end
    test_reset();
    test_bring_up();
    test_round_robin();
    test_credit_exhaustion();
    test_backpressure();
    test_seq_wrap();
    test_link_drop();
    test_credit_err();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "simulation time limit");
  end

endmodule
